// File: rtl/power_isa_pkg.sv
// Power ISA v3.1 encoding constants shared by the instruction encoder.
// Bit numbering in comments follows the ISA (bit 0 = MSB of the word).
package power_isa_pkg;

  // Request operation codes; 15 is deliberately left undefined.
  typedef enum logic [3:0] {
    OP_B       = 4'd0,
    OP_BC      = 4'd1,
    OP_BCLR    = 4'd2,
    OP_BCCTR   = 4'd3,
    OP_BCTAR   = 4'd4,
    OP_CRAND   = 4'd5,
    OP_CRNAND  = 4'd6,
    OP_CROR    = 4'd7,
    OP_CRXOR   = 4'd8,
    OP_CRNOR   = 4'd9,
    OP_CREQV   = 4'd10,
    OP_CRANDC  = 4'd11,
    OP_CRORC   = 4'd12,
    OP_MCRF    = 4'd13,
    OP_RAW_PFX = 4'd14,
    OP_UNDEF   = 4'd15
  } op_e;

  // Encoder sequencing: IDLE accepts requests, SUFFIX owes the second prefixed word.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SUFFIX = 1'b1
  } state_e;

  // Primary opcodes (ISA bits 0:5).
  localparam logic [5:0] PO_PFX = 6'd1;
  localparam logic [5:0] PO_BC  = 6'd16;
  localparam logic [5:0] PO_B   = 6'd18;
  localparam logic [5:0] PO_XL  = 6'd19;

  // Extended opcodes for XL-form (ISA bits 21:30).
  localparam logic [9:0] XO_MCRF   = 10'd0;
  localparam logic [9:0] XO_BCLR   = 10'd16;
  localparam logic [9:0] XO_CRNOR  = 10'd33;
  localparam logic [9:0] XO_CRANDC = 10'd129;
  localparam logic [9:0] XO_CRXOR  = 10'd193;
  localparam logic [9:0] XO_CRNAND = 10'd225;
  localparam logic [9:0] XO_CRAND  = 10'd257;
  localparam logic [9:0] XO_CREQV  = 10'd289;
  localparam logic [9:0] XO_CRORC  = 10'd417;
  localparam logic [9:0] XO_CROR   = 10'd449;
  localparam logic [9:0] XO_BCCTR  = 10'd528;
  localparam logic [9:0] XO_BCTAR  = 10'd560;

  // Field widths used when packing words.
  localparam int LI_W  = 24;
  localparam int BD_W  = 14;
  localparam int FLD_W = 5;
  localparam int CRF_W = 3;
  localparam int PFX_W = 26;

  // Extended opcode for any XL-form op; zero for ops that are not XL-form.
  function automatic logic [9:0] xl_xo(input op_e op);
    logic [9:0] xo;
    xo = 10'd0;
    case (op)
      OP_BCLR:   xo = XO_BCLR;
      OP_BCCTR:  xo = XO_BCCTR;
      OP_BCTAR:  xo = XO_BCTAR;
      OP_CRAND:  xo = XO_CRAND;
      OP_CRNAND: xo = XO_CRNAND;
      OP_CROR:   xo = XO_CROR;
      OP_CRXOR:  xo = XO_CRXOR;
      OP_CRNOR:  xo = XO_CRNOR;
      OP_CREQV:  xo = XO_CREQV;
      OP_CRANDC: xo = XO_CRANDC;
      OP_CRORC:  xo = XO_CRORC;
      default:   xo = XO_MCRF;
    endcase
    return xo;
  endfunction

endpackage

// File: rtl/instr_word_pack.sv
// Combinational packer: op + fields -> one 32-bit Power ISA word.
// With INSTR_ENCODER_CHECK_EN defined it also flags requests that must not be emitted.
module instr_word_pack
  import power_isa_pkg::*;
(
  input  logic [3:0]        i_op,
  input  logic [FLD_W-1:0]  i_f0,
  input  logic [FLD_W-1:0]  i_f1,
  input  logic [FLD_W-1:0]  i_f2,
  input  logic [1:0]        i_bh,
  input  logic [LI_W-1:0]   i_disp,
  input  logic              i_aa,
  input  logic              i_lk,
  input  logic [PFX_W-1:0]  i_pfx_payload,
`ifdef INSTR_ENCODER_CHECK_EN
  input  logic [5:0]        i_sfx_opcode,
  output logic              o_illegal,
`endif
  output logic [31:0]       o_word
);

  op_e op;
  assign op = op_e'(i_op);

  // Select the instruction form and concatenate fields MSB-first.
  always_comb begin
    o_word = 32'h0;
    case (op)
      OP_B:
        o_word = {PO_B, i_disp, i_aa, i_lk};
      OP_BC:
        o_word = {PO_BC, i_f0, i_f1, i_disp[BD_W-1:0], i_aa, i_lk};
      OP_BCLR, OP_BCCTR, OP_BCTAR:
        // Bits 16:18 are reserved zero; BH sits in bits 19:20.
        o_word = {PO_XL, i_f0, i_f1, 3'b000, i_bh, xl_xo(op), i_lk};
      OP_CRAND, OP_CRNAND, OP_CROR, OP_CRXOR,
      OP_CRNOR, OP_CREQV, OP_CRANDC, OP_CRORC:
        o_word = {PO_XL, i_f0, i_f1, i_f2, xl_xo(op), 1'b0};
      OP_MCRF:
        // CR field numbers are 3 bits; the low two bits of each 5-bit slot stay zero.
        o_word = {PO_XL, i_f0[CRF_W-1:0], 2'b00, i_f1[CRF_W-1:0], 2'b00,
                  5'b00000, XO_MCRF, 1'b0};
      OP_RAW_PFX:
        o_word = {PO_PFX, i_pfx_payload};
      default:
        o_word = 32'h0;
    endcase
  end

`ifdef INSTR_ENCODER_CHECK_EN
  // Flag requests that would produce a malformed or reserved encoding.
  always_comb begin
    o_illegal = 1'b0;
    case (op)
      OP_UNDEF:   o_illegal = 1'b1;
      // BO bit 2 (ISA numbering) clear would decrement CTR while branching to it.
      OP_BCCTR:   o_illegal = !i_f0[2] || (i_bh == 2'b10);
      OP_BCLR,
      OP_BCTAR:   o_illegal = (i_bh == 2'b10);
      OP_RAW_PFX: o_illegal = (i_sfx_opcode == PO_PFX);
      default:    o_illegal = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder top: request handshake, output word register, prefixed-pair sequencing.
// Optional build macro: INSTR_ENCODER_CHECK_EN enables illegal-request screening and o_illegal.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
// Once valid is raised the producer holds it and its payload until that edge. The
// request side is i_req_valid/o_req_ready; the output side is o_instr_valid/i_instr_ready.
module instr_encoder
  import power_isa_pkg::*;
#(
  parameter bit ZERO_IDLE = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_req_valid,
  output logic         o_req_ready,
  input  logic [3:0]   i_req_op,
  input  logic [4:0]   i_f0,
  input  logic [4:0]   i_f1,
  input  logic [4:0]   i_f2,
  input  logic [1:0]   i_bh,
  input  logic [23:0]  i_disp,
  input  logic         i_aa,
  input  logic         i_lk,
  input  logic [25:0]  i_pfx_payload,
  input  logic [31:0]  i_raw_suffix,
  output logic         o_instr_valid,
  input  logic         i_instr_ready,
  output logic [31:0]  o_instr,
  output logic         o_illegal,
  output state_e       o_dbg_state
);

  state_e      state_q, state_d;
  logic [31:0] instr_q;
  logic        instr_valid_q;
  logic [31:0] suffix_q;
  logic [31:0] pack_word;
  logic        req_illegal;
  logic        req_fire;
  logic        out_fire;
  logic        is_raw;
  logic        load_word;
  logic        load_suffix;

  instr_word_pack u_pack (
    .i_op          (i_req_op),
    .i_f0          (i_f0),
    .i_f1          (i_f1),
    .i_f2          (i_f2),
    .i_bh          (i_bh),
    .i_disp        (i_disp),
    .i_aa          (i_aa),
    .i_lk          (i_lk),
    .i_pfx_payload (i_pfx_payload),
`ifdef INSTR_ENCODER_CHECK_EN
    .i_sfx_opcode  (i_raw_suffix[31:26]),
    .o_illegal     (req_illegal),
`endif
    .o_word        (pack_word)
  );

`ifndef INSTR_ENCODER_CHECK_EN
  // Without screening every request is encoded literally.
  assign req_illegal = 1'b0;
`endif

  // Ready only depends on internal state and the consumer, never on i_req_valid.
  assign o_req_ready = !i_rst && (state_q == ST_IDLE) && (!instr_valid_q || i_instr_ready);
  assign req_fire    = i_req_valid && o_req_ready;
  assign out_fire    = instr_valid_q && i_instr_ready;
  assign is_raw      = (op_e'(i_req_op) == OP_RAW_PFX);

  assign o_instr_valid = instr_valid_q;
  assign o_instr       = (ZERO_IDLE && !instr_valid_q) ? 32'h0 : instr_q;
  assign o_dbg_state   = state_q;

  // Next-state and datapath load decisions.
  always_comb begin
    state_d     = state_q;
    load_word   = 1'b0;
    load_suffix = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_fire && !req_illegal) begin
          load_word = 1'b1;
          if (is_raw) state_d = ST_SUFFIX;
        end
      end
      ST_SUFFIX: begin
        // The suffix replaces the prefix on the very edge the prefix is taken.
        if (out_fire) begin
          load_suffix = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Output word register: load new word, swap in suffix, or retire on handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      instr_q       <= 32'h0;
      instr_valid_q <= 1'b0;
    end else if (load_word) begin
      instr_q       <= pack_word;
      instr_valid_q <= 1'b1;
    end else if (load_suffix) begin
      instr_q       <= suffix_q;
      instr_valid_q <= 1'b1;
    end else if (out_fire) begin
      instr_valid_q <= 1'b0;
    end
  end

  // Suffix buffer captured at prefix accept so the requester may move on.
  always_ff @(posedge i_clk) begin
    if (i_rst)                 suffix_q <= 32'h0;
    else if (req_fire && is_raw) suffix_q <= i_raw_suffix;
  end

`ifdef INSTR_ENCODER_CHECK_EN
  logic illegal_q;

  // One-cycle pulse for a consumed request that produced no word.
  always_ff @(posedge i_clk) begin
    if (i_rst) illegal_q <= 1'b0;
    else       illegal_q <= req_fire && req_illegal;
  end

  assign o_illegal = illegal_q;
`else
  assign o_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed requests, expected-word queue, monitor.
// Build with +define+INSTR_ENCODER_CHECK_EN to exercise the illegal-request screening.
`timescale 1ns/1ps
module tb_instr_encoder;
  import power_isa_pkg::*;

  logic         i_clk;
  logic         i_rst;
  logic         i_req_valid;
  logic         o_req_ready;
  logic [3:0]   i_req_op;
  logic [4:0]   i_f0, i_f1, i_f2;
  logic [1:0]   i_bh;
  logic [23:0]  i_disp;
  logic         i_aa, i_lk;
  logic [25:0]  i_pfx_payload;
  logic [31:0]  i_raw_suffix;
  logic         o_instr_valid;
  logic         i_instr_ready;
  logic [31:0]  o_instr;
  logic         o_illegal;
  state_e       o_dbg_state;

  logic [31:0]  exp_q[$];
  int           checks;
  int           errors;
  int           cyc;
  int           acc_cyc;

  instr_encoder #(.ZERO_IDLE(1'b1)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_op      (i_req_op),
    .i_f0          (i_f0),
    .i_f1          (i_f1),
    .i_f2          (i_f2),
    .i_bh          (i_bh),
    .i_disp        (i_disp),
    .i_aa          (i_aa),
    .i_lk          (i_lk),
    .i_pfx_payload (i_pfx_payload),
    .i_raw_suffix  (i_raw_suffix),
    .o_instr_valid (o_instr_valid),
    .i_instr_ready (i_instr_ready),
    .o_instr       (o_instr),
    .o_illegal     (o_illegal),
    .o_dbg_state   (o_dbg_state)
  );

  // Clock and cycle counter.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  initial cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_fields();
    i_req_op      = 4'd0;
    i_f0          = 5'd0;
    i_f1          = 5'd0;
    i_f2          = 5'd0;
    i_bh          = 2'd0;
    i_disp        = 24'd0;
    i_aa          = 1'b0;
    i_lk          = 1'b0;
    i_pfx_payload = 26'd0;
    i_raw_suffix  = 32'd0;
  endtask

  // Present the request already on the field inputs; queue n_words expected words at accept.
  // Returns 1ns after the accepting edge.
  task automatic do_req(input int n_words, input logic [31:0] w0, input logic [31:0] w1);
    int n;
    n = 0;
    i_req_valid = 1'b1;
    @(negedge i_clk);
    while (!o_req_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_accept_timeout: o_req_ready stayed 0 for %0d cycles, required 1", n);
      i_req_valid = 1'b0;
    end else begin
      if (n_words > 0) exp_q.push_back(w0);
      if (n_words > 1) exp_q.push_back(w1);
      acc_cyc = cyc;
      @(posedge i_clk);
      #1;
      i_req_valid = 1'b0;
    end
  endtask

  // Monitor: every output handshake must match the head of the expected queue.
  always @(negedge i_clk) begin
    if (!i_rst && o_instr_valid && i_instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got word 0x%08h, required no word", o_instr);
      end else begin
        check("sb_word", o_instr, exp_q.pop_front());
      end
    end
  end

  initial begin
    int a1;
    int n;
    checks        = 0;
    errors        = 0;
    acc_cyc       = 0;
    i_rst         = 1'b1;
    i_req_valid   = 1'b0;
    i_instr_ready = 1'b1;
    clear_fields();

    // Reset state.
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_valid", {31'd0, o_instr_valid}, 32'd0);
    check("rst_instr", o_instr, 32'h0);
    check("rst_illegal", {31'd0, o_illegal}, 32'd0);
    check("rst_req_ready", {31'd0, o_req_ready}, 32'd0);
    check("rst_state", {31'd0, o_dbg_state}, {31'd0, ST_IDLE});
    @(posedge i_clk);
    #1 i_rst = 1'b0;

    // B disp=1 LK=1: valid one cycle after accept.
    clear_fields();
    i_req_op = OP_B; i_disp = 24'd1; i_lk = 1'b1;
    do_req(1, 32'h48000005, 32'h0);
    check("b_latency_valid", {31'd0, o_instr_valid}, 32'd1);
    check("b_latency_word", o_instr, 32'h48000005);

    // CRAND then MCRF back-to-back.
    clear_fields();
    i_req_op = OP_CRAND; i_f0 = 5'd1; i_f1 = 5'd2; i_f2 = 5'd3;
    do_req(1, 32'h4C221A02, 32'h0);
    a1 = acc_cyc;
    check("crand_valid", {31'd0, o_instr_valid}, 32'd1);
    clear_fields();
    i_req_op = OP_MCRF; i_f0 = 5'd1; i_f1 = 5'd7;
    do_req(1, 32'h4C9C0000, 32'h0);
    check("b2b_accept_gap", acc_cyc - a1, 32'd1);
    check("mcrf_valid", {31'd0, o_instr_valid}, 32'd1);

    // Boundary encodings: excess field bits, full-width displacement, max fields.
    clear_fields();
    i_req_op = OP_MCRF; i_f0 = 5'b11001; i_f1 = 5'b11111; i_f2 = 5'd31;
    do_req(1, 32'h4C9C0000, 32'h0);
    clear_fields();
    i_req_op = OP_B; i_disp = 24'hFFFFFF; i_aa = 1'b1;
    do_req(1, 32'h4BFFFFFE, 32'h0);
    clear_fields();
    i_req_op = OP_CROR; i_f0 = 5'd31; i_f1 = 5'd31; i_f2 = 5'd31;
    do_req(1, 32'h4FFFFB82, 32'h0);
    clear_fields();
    i_req_op = OP_BC; i_f0 = 5'd12; i_f1 = 5'd2; i_disp = 24'hFFC010;
    do_req(1, 32'h41820040, 32'h0);
    clear_fields();
    i_req_op = OP_BCTAR; i_f0 = 5'd20; i_bh = 2'd3; i_lk = 1'b1;
    do_req(1, 32'h4E801C61, 32'h0);

    // BCLR then BCCTR stalled for 3 cycles.
    clear_fields();
    i_req_op = OP_BCLR; i_f0 = 5'd20;
    do_req(1, 32'h4E800020, 32'h0);
    clear_fields();
    i_req_op = OP_BCCTR; i_f0 = 5'd20;
    do_req(1, 32'h4E800420, 32'h0);
    i_instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("stall_word", o_instr, 32'h4E800420);
      check("stall_valid", {31'd0, o_instr_valid}, 32'd1);
      check("stall_req_ready", {31'd0, o_req_ready}, 32'd0);
    end
    @(posedge i_clk);
    #1 i_instr_ready = 1'b1;

    // Raw prefixed pair with prefix stalled 2 cycles.
    clear_fields();
    i_req_op = OP_RAW_PFX; i_pfx_payload = 26'h123; i_raw_suffix = 32'h38600000;
    do_req(2, 32'h04000123, 32'h38600000);
    i_instr_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      check("pfx_hold_word", o_instr, 32'h04000123);
      check("pfx_req_ready", {31'd0, o_req_ready}, 32'd0);
    end
    @(posedge i_clk);
    #1 i_instr_ready = 1'b1;
    @(negedge i_clk);
    check("pfx_take_req_ready", {31'd0, o_req_ready}, 32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    check("sfx_word", o_instr, 32'h38600000);
    check("sfx_valid", {31'd0, o_instr_valid}, 32'd1);
    check("sfx_req_ready", {31'd0, o_req_ready}, 32'd1);
    @(posedge i_clk);
    #1;

`ifdef INSTR_ENCODER_CHECK_EN
    // Illegal BCCTR: consumed, no word, one-cycle o_illegal; next B normal.
    clear_fields();
    i_req_op = OP_BCCTR; i_f0 = 5'd0;
    do_req(0, 32'h0, 32'h0);
    check("illegal_pulse", {31'd0, o_illegal}, 32'd1);
    check("illegal_no_word", {31'd0, o_instr_valid}, 32'd0);
    @(posedge i_clk);
    #1;
    check("illegal_pulse_end", {31'd0, o_illegal}, 32'd0);
    clear_fields();
    i_req_op = OP_B; i_disp = 24'd1; i_lk = 1'b1;
    do_req(1, 32'h48000005, 32'h0);
    check("after_illegal_valid", {31'd0, o_instr_valid}, 32'd1);
`else
    // Without screening these are encoded literally; op 15 becomes 32'h0.
    clear_fields();
    i_req_op = 4'd15;
    do_req(1, 32'h00000000, 32'h0);
    check("undef_valid", {31'd0, o_instr_valid}, 32'd1);
    clear_fields();
    i_req_op = OP_BCCTR; i_f0 = 5'd0;
    do_req(1, 32'h4C000420, 32'h0);
    check("no_illegal", {31'd0, o_illegal}, 32'd0);
`endif

    // Drain, then idle output must read zero.
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("idle_valid", {31'd0, o_instr_valid}, 32'd0);
    check("idle_zero", o_instr, 32'h0);
    @(posedge i_clk);
    #1;

    // Reset while the suffix is still owed.
    i_instr_ready = 1'b0;
    clear_fields();
    i_req_op = OP_RAW_PFX; i_pfx_payload = 26'h3FFFFFF; i_raw_suffix = 32'h12345678;
    do_req(2, 32'h07FFFFFF, 32'h12345678);
    check("mid_pair_state", {31'd0, o_dbg_state}, {31'd0, ST_SUFFIX});
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    check("mid_rst_valid", {31'd0, o_instr_valid}, 32'd0);
    check("mid_rst_instr", o_instr, 32'h0);
    check("mid_rst_req_ready", {31'd0, o_req_ready}, 32'd0);
    check("mid_rst_state", {31'd0, o_dbg_state}, {31'd0, ST_IDLE});
    exp_q.delete();
    i_rst = 1'b0;
    i_instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      check("mid_rst_no_suffix", {31'd0, o_instr_valid}, 32'd0);
    end

    // Bounded wait for any outstanding expected words.
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge i_clk);
      n++;
    end
    check("sb_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
